// File: rtl/fb_pixel_reader_pkg.sv
// Shared types for the framebuffer pixel reader: FSM states, RGB332 field
// positions, prefetch FIFO entry layout and RGB332->RGB888 expansion helpers.
package fb_pixel_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam int unsigned R_MSB = 7;
   localparam int unsigned R_LSB = 5;
   localparam int unsigned G_MSB = 4;
   localparam int unsigned G_LSB = 2;
   localparam int unsigned B_MSB = 1;
   localparam int unsigned B_LSB = 0;

   typedef struct packed {
      logic       sof;
      logic       sol;
      logic [7:0] data;
   } fifo_entry_t;

   localparam int unsigned FIFO_W = $bits(fifo_entry_t);

   // Bit replication so full-scale codes map to 0xFF and zero to 0x00
   function automatic logic [7:0] expand_r(input logic [7:0] p);
      logic [2:0] r;
      r = p[R_MSB:R_LSB];
      return {r, r, r[2:1]};
   endfunction

   function automatic logic [7:0] expand_g(input logic [7:0] p);
      logic [2:0] g;
      g = p[G_MSB:G_LSB];
      return {g, g, g[2:1]};
   endfunction

   function automatic logic [7:0] expand_b(input logic [7:0] p);
      logic [1:0] b;
      b = p[B_MSB:B_LSB];
      return {b, b, b, b};
   endfunction

endpackage

// File: rtl/fb_pixel_reader_if.sv
// Framebuffer read port plus pixel stream bundle for fb_pixel_reader.
interface fb_pixel_reader_if #(
   parameter int unsigned ADDR_W = 17
);
   logic              start;
   logic              fb_rd_en;
   logic [ADDR_W-1:0] fb_addr;
   logic [7:0]        fb_rd_data;
   logic [7:0]        pix_r;
   logic [7:0]        pix_g;
   logic [7:0]        pix_b;
   logic              pix_sof;
   logic              pix_sol;
   logic              pix_valid;
   logic              pix_ready;
   logic              busy;
   logic              frame_done;

   modport master (
      input  start, fb_rd_data, pix_ready,
      output fb_rd_en, fb_addr, pix_r, pix_g, pix_b, pix_sof, pix_sol,
             pix_valid, busy, frame_done
   );

   modport slave (
      output start, fb_rd_data, pix_ready,
      input  fb_rd_en, fb_addr, pix_r, pix_g, pix_b, pix_sof, pix_sol,
             pix_valid, busy, frame_done
   );
endinterface

// File: rtl/fb_pixel_reader_sync_fifo.sv
// Generic synchronous FIFO with count/full/empty; power-of-two depth.
// Push+pop on empty passes data straight through; push+pop on full is allowed.
module fb_pixel_reader_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       pop_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push_c, do_pop_c;

   assign full     = (count_q == (PTR_W+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = empty ? push_data : mem_q[rd_ptr_q];

   always_comb begin
      do_push_c = push && (!full || pop);
      do_pop_c  = pop && (!empty || push);
      wr_ptr_d  = wr_ptr_q + PTR_W'(do_push_c);
      rd_ptr_d  = rd_ptr_q + PTR_W'(do_pop_c);
      count_d   = count_q + (PTR_W+1)'(do_push_c) - (PTR_W+1)'(do_pop_c);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: contents are only visible once counted in
   always_ff @(posedge clk) begin
      if (do_push_c) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/fb_pixel_reader.sv
// Linear RGB332 framebuffer scanner producing an RGB888 valid/ready stream.
// Define FB_READER_CONTINUOUS_EN to rescan frames back to back without start.
module fb_pixel_reader
   import fb_pixel_reader_pkg::*;
#(
   parameter int unsigned H_RES      = 320,
   parameter int unsigned V_RES      = 240,
   parameter int unsigned ADDR_W     = 17,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   fb_pixel_reader_if.master   bus
);
   localparam int unsigned TOTAL = H_RES * V_RES;
   localparam int unsigned X_W   = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int unsigned Y_W   = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned LVL_W = CNT_W + 1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [X_W-1:0]    x_q, x_d;
   logic [Y_W-1:0]    y_q, y_d;
   logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
   logic              rd_en_q, rd_en_d;
   logic              ret_q, ret_d;
   logic              ret_sof_q, ret_sof_d;
   logic              ret_sol_q, ret_sol_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              last_issue_c, last_pix_c, pop_c, pix_valid_c;
   logic [LVL_W-1:0]  level_c;
   fifo_entry_t       push_entry_c, head_c;
   logic              fifo_full, fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic              unused_ok;

   assign push_entry_c = '{sof: ret_sof_q, sol: ret_sol_q, data: bus.fb_rd_data};
   assign pix_valid_c  = !fifo_empty;
   assign pop_c        = pix_valid_c && bus.pix_ready;
   assign unused_ok    = fifo_full;

   fb_pixel_reader_sync_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (ret_q),
      .push_data (push_entry_c),
      .pop       (pop_c),
      .pop_data  (head_c),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      x_d       = x_q;
      y_d       = y_q;
      pix_cnt_d = pix_cnt_q;
      busy_d    = busy_q;
      ret_d     = rd_en_q;
      ret_sol_d = (x_q == '0);
      ret_sof_d = (x_q == '0) && (y_q == '0);

      last_issue_c = rd_en_q && (addr_q == ADDR_W'(TOTAL - 1));
      last_pix_c   = pop_c && (pix_cnt_q == ADDR_W'(TOTAL - 1));
      done_d       = last_pix_c;

      // Scan counters advance with each issued read
      if (rd_en_q) begin
         addr_d = last_issue_c ? '0 : addr_q + ADDR_W'(1);
         if (x_q == X_W'(H_RES - 1)) begin
            x_d = '0;
            y_d = (y_q == Y_W'(V_RES - 1)) ? '0 : y_q + Y_W'(1);
         end else begin
            x_d = x_q + X_W'(1);
         end
      end

      if (pop_c) pix_cnt_d = last_pix_c ? '0 : pix_cnt_q + ADDR_W'(1);

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_FETCH;
               busy_d  = 1'b1;
            end
         end
         ST_FETCH: begin
`ifdef FB_READER_CONTINUOUS_EN
            if (last_issue_c) state_d = ST_FETCH;
`else
            if (last_issue_c) state_d = ST_DRAIN;
`endif
         end
         ST_DRAIN: begin
            if (last_pix_c) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Occupancy next cycle plus the read returning then must leave room
      level_c = LVL_W'(fifo_count) + LVL_W'(ret_q) - LVL_W'(pop_c) + LVL_W'(rd_en_q);
      rd_en_d = (state_d == ST_FETCH) && (level_c < LVL_W'(FIFO_DEPTH));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         x_q       <= '0;
         y_q       <= '0;
         pix_cnt_q <= '0;
         rd_en_q   <= 1'b0;
         ret_q     <= 1'b0;
         ret_sof_q <= 1'b0;
         ret_sol_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         x_q       <= x_d;
         y_q       <= y_d;
         pix_cnt_q <= pix_cnt_d;
         rd_en_q   <= rd_en_d;
         ret_q     <= ret_d;
         ret_sof_q <= ret_sof_d;
         ret_sol_q <= ret_sol_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.fb_rd_en   = rd_en_q;
   assign bus.fb_addr    = addr_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = done_q;
   assign bus.pix_valid  = pix_valid_c;
   assign bus.pix_r      = pix_valid_c ? expand_r(head_c.data) : 8'h00;
   assign bus.pix_g      = pix_valid_c ? expand_g(head_c.data) : 8'h00;
   assign bus.pix_b      = pix_valid_c ? expand_b(head_c.data) : 8'h00;
   assign bus.pix_sof    = pix_valid_c && head_c.sof;
   assign bus.pix_sol    = pix_valid_c && head_c.sol;

endmodule

// File: tb/tb_fb_pixel_reader.sv
// Directed bench for fb_pixel_reader on a 4x2 frame with a 1-cycle latency
// framebuffer model; honours FB_READER_CONTINUOUS_EN when defined.
module tb_fb_pixel_reader;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   logic [7:0]  mem     [8];
   logic [23:0] exp_tab [8];

   fb_pixel_reader_if #(.ADDR_W(3)) bus ();

   fb_pixel_reader #(
      .H_RES      (4),
      .V_RES      (2),
      .ADDR_W     (3),
      .FIFO_DEPTH (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.fb_rd_en) bus.fb_rd_data <= mem[bus.fb_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ctrl"}, {bus.fb_rd_en, bus.fb_addr, bus.pix_sof, bus.pix_sol,
                          bus.pix_valid, bus.busy, bus.frame_done}, 32'h0);
      chk({tag, "_rgb"}, {bus.pix_r, bus.pix_g, bus.pix_b}, 32'h0);
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("start_rd_en", bus.fb_rd_en, 1);
      chk("start_addr", bus.fb_addr, 0);
      chk("start_busy", bus.busy, 1);
   endtask

   // Runs one frame from the cycle after start; extra_st >= 0 pulses start mid-frame
   task automatic collect(input string tag, input int budget, input logic [3:0] pat,
                          input int extra_st);
      int          n;
      int          done_cnt;
      int          done_at;
      int          last_acc;
      int          first_v;
      bit          stalled;
      bit          gap;
      logic [25:0] held;
      logic [25:0] cur;
      n = 0; done_cnt = 0; done_at = -1; last_acc = -1; first_v = -1;
      stalled = 1'b0; gap = 1'b0; held = '0;
      for (int c = 0; c < budget; c++) begin
         bus.pix_ready = pat[c % 4];
         bus.start     = (extra_st >= 0) && (c == extra_st || c == extra_st + 4);
         cur = {bus.pix_sof, bus.pix_sol, bus.pix_r, bus.pix_g, bus.pix_b};
         if (stalled) chk({tag, "_stall_hold"}, 32'(cur), 32'(held));
         stalled = 1'b0;
         if (bus.frame_done) begin
            done_cnt++;
            done_at = c;
            chk({tag, "_busy_at_done"}, bus.busy, 0);
         end
         if (bus.pix_valid && first_v < 0) first_v = c;
         if (bus.pix_valid && bus.pix_ready) begin
            if (n < 8)
               chk({tag, "_pix"}, 32'(cur), 32'({n == 0, n == 0 || n == 4, exp_tab[n]}));
            if (n > 0 && c != last_acc + 1) gap = 1'b1;
            last_acc = c;
            n++;
         end else if (bus.pix_valid) begin
            stalled = 1'b1;
            held    = cur;
         end
         step();
      end
      bus.start     = 1'b0;
      bus.pix_ready = 1'b1;
      chk({tag, "_first_valid"}, first_v, 2);
      chk({tag, "_pix_count"}, n, 8);
      chk({tag, "_done_count"}, done_cnt, 1);
      chk({tag, "_done_timing"}, done_at, last_acc + 1);
      if (pat == 4'hF) chk({tag, "_no_gap"}, 32'(gap), 0);
      chk({tag, "_idle_busy"}, bus.busy, 0);
      chk({tag, "_idle_rd_en"}, bus.fb_rd_en, 0);
   endtask

   task automatic load_ramp();
      for (int i = 0; i < 8; i++) mem[i] = 8'(i);
      exp_tab[0] = 24'h000000; exp_tab[1] = 24'h000055;
      exp_tab[2] = 24'h0000AA; exp_tab[3] = 24'h0000FF;
      exp_tab[4] = 24'h002400; exp_tab[5] = 24'h002455;
      exp_tab[6] = 24'h0024AA; exp_tab[7] = 24'h0024FF;
   endtask

   initial begin
      int n;
      int dn;
      reset          = 1'b1;
      bus.start      = 1'b0;
      bus.pix_ready  = 1'b1;
      bus.fb_rd_data = 8'h00;
      load_ramp();
      step();
      step();
      check_zero("reset");
      reset = 1'b0;
      step();
      check_zero("idle");

`ifdef FB_READER_CONTINUOUS_EN
      pulse_start();
      n = 0; dn = 0;
      for (int c = 0; c < 27; c++) begin
         if (c < 24) begin
            chk("cont_rd_en", bus.fb_rd_en, 1);
            chk("cont_addr", bus.fb_addr, 32'(c % 8));
         end
         if (bus.frame_done) begin
            dn++;
            chk("cont_done_spacing", n, dn * 8);
         end
         if (bus.pix_valid && bus.pix_ready) begin
            chk("cont_pix", {bus.pix_sof, bus.pix_sol, bus.pix_r, bus.pix_g, bus.pix_b},
                32'({n % 8 == 0, n % 4 == 0, exp_tab[n % 8]}));
            n++;
         end
         step();
      end
      chk("cont_done_count", dn, 3);
      chk("cont_busy", bus.busy, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_zero("cont_reset");
`else
      // Ramp frame at full rate
      pulse_start();
      collect("ramp", 16, 4'hF, -1);

      // Expansion vectors
      mem[0] = 8'hFF; mem[1] = 8'h00; mem[2] = 8'hE0; mem[3] = 8'h1C;
      mem[4] = 8'h03; mem[5] = 8'h92; mem[6] = 8'h88; mem[7] = 8'h6D;
      exp_tab[0] = 24'hFFFFFF; exp_tab[1] = 24'h000000;
      exp_tab[2] = 24'hFF0000; exp_tab[3] = 24'h00FF00;
      exp_tab[4] = 24'h0000FF; exp_tab[5] = 24'h9292AA;
      exp_tab[6] = 24'h924900; exp_tab[7] = 24'h6D6D55;
      pulse_start();
      collect("expand", 16, 4'hF, -1);

      // Backpressure with ready pattern 1,0,0,1
      load_ramp();
      pulse_start();
      collect("bp", 40, 4'b1001, -1);

      // Mid-frame reset after three pixels accepted, then a clean rescan
      pulse_start();
      repeat (5) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_zero("midreset");
      step();
      chk("midreset_discard_valid", bus.pix_valid, 0);
      chk("midreset_busy", bus.busy, 0);
      pulse_start();
      collect("rescan", 16, 4'hF, -1);

      // start while busy is ignored
      pulse_start();
      collect("restart", 24, 4'hF, 4);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
